// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: types shared by the datapath, the RAM model and the memory
// arbiter.
//   word_t      32-bit machine word
//   ramstate_t  RAM handshake status (FREE, BUSY, ACCESS, ERROR)
//   arb_state_t memory arbiter grant state, values ARB_IDLE / ARB_IFETCH / ARB_DATA
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ARB_IDLE   = 2'd0;
  localparam arb_state_t ARB_IFETCH = 2'd1;
  localparam arb_state_t ARB_DATA   = 2'd2;

  localparam word_t WORD_ZERO = 32'h0000_0000;

  // True in the single cycle the RAM reports the granted transfer as done.
  function automatic logic is_access(input logic [1:0] st);
    return (st == ACCESS);
  endfunction

endpackage

// File: rtl/arb_starve_counter.sv
// arb_starve_counter: saturating count of data completions that happened while
// a fetch was waiting. Only built when IFETCH_STARVE_GUARD_EN is defined.
// Ports:
//   CLK  in  clock, rising edge
//   RST  in  asynchronous active-high reset (count -> 0)
//   inc  in  data completion with a fetch pending
//   clr  in  fetch completion, or data completion with no fetch pending
//   sat  out count has reached STARVE_MAX
`ifdef IFETCH_STARVE_GUARD_EN
module arb_starve_counter #(
  parameter int STARVE_MAX = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_r;

  // Saturating counter; clear has priority, never wraps.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (inc && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign sat = (cnt_r == CNT_MAX);

endmodule
`endif

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares the single RAM port between instruction fetch (IF)
// and data access (MEM). Data side has priority because MEM is older in the
// pipe. The grant is registered; the RAM port and the wait/load returns are
// driven combinationally from the granted side. After every completion the
// arbiter spends one cycle in ARB_IDLE before the next grant.
// Build option: IFETCH_STARVE_GUARD_EN -- after STARVE_MAX data completions
// with a fetch pending, the next idle-cycle grant goes to fetch.
// Ports:
//   CLK, RST                 clock / asynchronous active-high reset
//   iREN, iaddr              fetch request; iwait, iload returned
//   dREN, dWEN, daddr,
//   dstore                   data request; dwait, dload returned
//   ramREN, ramWEN, ramaddr,
//   ramstore                 RAM request port
//   ramload, ramstate        RAM response
module memory_arbiter
  import cpu_types_pkg::*;
`ifdef IFETCH_STARVE_GUARD_EN
#(
  parameter int STARVE_MAX = 4
)
`endif
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
);

  arb_state_t state_r;
  arb_state_t state_nxt_s;
  logic       d_req_s;
  logic       i_done_s;
  logic       d_done_s;
  logic       fetch_force_s;

  assign d_req_s = dREN | dWEN;

`ifdef IFETCH_STARVE_GUARD_EN
  logic starve_sat_s;
  logic starve_inc_s;
  logic starve_clr_s;

  assign starve_inc_s = d_done_s & iREN;
  assign starve_clr_s = i_done_s | (d_done_s & ~iREN);

  arb_starve_counter #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .CLK (CLK),
    .RST (RST),
    .inc (starve_inc_s),
    .clr (starve_clr_s),
    .sat (starve_sat_s)
  );

  assign fetch_force_s = starve_sat_s & iREN;
`else
  assign fetch_force_s = 1'b0;
`endif

  // RAM port and requester returns, muxed from the registered grant.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = WORD_ZERO;
    ramstore = WORD_ZERO;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = WORD_ZERO;
    dload    = WORD_ZERO;
    i_done_s = 1'b0;
    d_done_s = 1'b0;
    case (state_r)
      ARB_DATA: begin
        // A simultaneous read and write is treated as the write.
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        if (d_req_s && is_access(ramstate)) begin
          d_done_s = 1'b1;
          dwait    = 1'b0;
          dload    = ramload;
        end else begin
          d_done_s = 1'b0;
        end
      end
      ARB_IFETCH: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        if (iREN && is_access(ramstate)) begin
          i_done_s = 1'b1;
          iwait    = 1'b0;
          iload    = ramload;
        end else begin
          i_done_s = 1'b0;
        end
      end
      default: begin
        ramREN = 1'b0;
      end
    endcase
  end

  // Grant selection; BUSY/FREE/ERROR keep the grant so the request is retried.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ARB_IDLE: begin
        if (fetch_force_s) begin
          state_nxt_s = ARB_IFETCH;
        end else if (d_req_s) begin
          state_nxt_s = ARB_DATA;
        end else if (iREN) begin
          state_nxt_s = ARB_IFETCH;
        end else begin
          state_nxt_s = ARB_IDLE;
        end
      end
      ARB_DATA: begin
        if (!d_req_s || d_done_s) begin
          state_nxt_s = ARB_IDLE;
        end else begin
          state_nxt_s = ARB_DATA;
        end
      end
      ARB_IFETCH: begin
        if (!iREN || i_done_s) begin
          state_nxt_s = ARB_IDLE;
        end else begin
          state_nxt_s = ARB_IFETCH;
        end
      end
      default: begin
        state_nxt_s = ARB_IDLE;
      end
    endcase
  end

  // Grant register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= ARB_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed scenarios plus randomized requesters against a
// port-ownership reference model; a small latency/error-injecting RAM lives here.
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  localparam int OWN_NONE   = 0;
  localparam int OWN_F      = 1;
  localparam int OWN_D      = 2;
  localparam int STARVE_MAX = 4;
`ifdef IFETCH_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        iREN = 1'b0;
  logic [31:0] iaddr = 32'h0;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN = 1'b0;
  logic        dWEN = 1'b0;
  logic [31:0] daddr = 32'h0;
  logic [31:0] dstore = 32'h0;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  int checks = 0;
  int errors = 0;

  memory_arbiter dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- RAM model: cfg_lat BUSY cycles, optional ERROR burst ----
  int cfg_lat = 0;
  int cfg_err = 0;
  int ram_cnt = 0;
  int err_left = 0;
  logic [31:0] mem [256] = '{default: 32'h0};

  function automatic logic [31:0] scramble(input logic [31:0] a);
    return {a[9:2], a[9:2], a[9:2], a[9:2]} ^ 32'h6C07_A5E1;
  endfunction

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    return mem[a[9:2]] ^ scramble(a);
  endfunction

  always_comb begin
    if (!(ramREN | ramWEN))     ramstate = FREE;
    else if (err_left > 0)      ramstate = ERROR;
    else if (ram_cnt >= cfg_lat) ramstate = ACCESS;
    else                        ramstate = BUSY;
  end

  always_comb ramload = mem[ramaddr[9:2]] ^ scramble(ramaddr);

  always @(posedge CLK) begin
    if (ramREN | ramWEN) begin
      if (ramstate == ERROR) begin
        err_left <= err_left - 1;
      end else if (ramstate == ACCESS) begin
        ram_cnt  <= 0;
        err_left <= cfg_err;
        if (ramWEN) mem[ramaddr[9:2]] <= ramstore ^ scramble(ramaddr);
      end else begin
        ram_cnt <= ram_cnt + 1;
      end
    end else begin
      ram_cnt  <= 0;
      err_left <= cfg_err;
    end
  end

  // ---------------- Reference model: who owns the RAM port -----------------
  int   m_grant = OWN_NONE;
  int   m_next = OWN_NONE;
  int   m_starve = 0;
  int   m_starve_next = 0;
  logic prev_en = 1'b0;
  int   obs_grants[$];

  always @(negedge CLK) begin : ref_model
    int own, nxt, s;
    logic dreq, acc, i_srv, d_srv, e_ren, e_wen;
    logic [31:0] e_addr, e_store;
    own = m_grant;
    dreq = dREN | dWEN;
    acc = (ramstate == ACCESS);
    e_ren = 1'b0; e_wen = 1'b0; e_addr = 32'h0; e_store = 32'h0;
    if (own == OWN_F) begin
      e_ren = iREN; e_addr = iaddr;
    end else if (own == OWN_D) begin
      e_wen = dWEN; e_ren = dREN & ~dWEN; e_addr = daddr; e_store = dstore;
    end
    i_srv = (own == OWN_F) && iREN && acc;
    d_srv = (own == OWN_D) && dreq && acc;
    check_eq("ramREN", ramREN, e_ren);
    check_eq("ramWEN", ramWEN, e_wen);
    check_eq("ramaddr", ramaddr, e_addr);
    check_eq("ramstore", ramstore, e_store);
    check_eq("iwait", iwait, !i_srv);
    check_eq("dwait", dwait, !d_srv);
    check_eq("iload", iload, i_srv ? ram_word(e_addr) : 32'h0);
    check_eq("dload", dload, d_srv ? ram_word(e_addr) : 32'h0);
    if (own == OWN_NONE) begin
      if (GUARD && m_starve == STARVE_MAX && iREN) nxt = OWN_F;
      else if (dreq)                               nxt = OWN_D;
      else if (iREN)                               nxt = OWN_F;
      else                                         nxt = OWN_NONE;
    end else if (own == OWN_D) begin
      nxt = (dreq && !d_srv) ? OWN_D : OWN_NONE;
    end else begin
      nxt = (iREN && !i_srv) ? OWN_F : OWN_NONE;
    end
    s = m_starve;
    if (d_srv) s = iREN ? ((s < STARVE_MAX) ? s + 1 : s) : 0;
    if (i_srv) s = 0;
    m_next <= nxt;
    m_starve_next <= s;
    // DUT-observed grant order (directed tests use distinct addresses per side).
    if ((ramREN | ramWEN) && !prev_en) obs_grants.push_back((ramaddr == daddr) ? OWN_D : OWN_F);
    prev_en <= ramREN | ramWEN;
  end

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_grant <= OWN_NONE;
      m_starve <= 0;
    end else begin
      m_grant <= m_next;
      m_starve <= m_starve_next;
    end
  end

  // ---------------- Stimulus helpers ----------------------------------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic go_idle(input int n);
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    for (int k = 0; k < n; k++) step();
  endtask

  // Waits for the side's wait to drop; cyc = cycles after the first sampled one.
  task automatic wait_done(input string tag, input int side, input int budget, output int cyc);
    cyc = 0;
    forever begin
      @(negedge CLK);
      if ((side == OWN_F && !iwait) || (side == OWN_D && !dwait)) break;
      cyc++;
      if (cyc > budget) begin
        check_eq({tag, "_timeout"}, cyc, budget);
        break;
      end
    end
  endtask

  function automatic int grant_at(input int idx);
    return (obs_grants.size() > idx) ? obs_grants[idx] : -1;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom & 32'h0000_03FC;
    return a;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c, base, kind;
    logic i_fin, d_fin;

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    check_eq("rst_iwait", iwait, 32'h1);
    check_eq("rst_dwait", dwait, 32'h1);
    check_eq("rst_ramREN", ramREN, 32'h0);
    check_eq("rst_ramaddr", ramaddr, 32'h0);
    RST = 1'b0;
    step();

    // 1: fetch with 2-cycle RAM latency, completes in cycle 3
    cfg_lat = 2; cfg_err = 0;
    iREN = 1'b1; iaddr = 32'h0000_0040;
    wait_done("t1", OWN_F, 20, c);
    check_eq("t1_latency", c, 32'd3);
    check_eq("t1_iload", iload, ram_word(32'h40));
    go_idle(2);

    // 2: simultaneous requests, data first, idle gap, then fetch
    cfg_lat = 1;
    base = obs_grants.size();
    dREN = 1'b1; daddr = 32'h200; iREN = 1'b1; iaddr = 32'h300;
    wait_done("t2_d", OWN_D, 20, c);
    check_eq("t2_dload", dload, ram_word(32'h200));
    step();
    dREN = 1'b0;
    @(negedge CLK);
    check_eq("t2_idle_gap", ramREN, 32'h0);
    wait_done("t2_i", OWN_F, 20, c);
    check_eq("t2_first", grant_at(base), OWN_D);
    check_eq("t2_second", grant_at(base + 1), OWN_F);
    go_idle(2);

    // 3: write wins over read, dwait low for one cycle, then read back
    dWEN = 1'b1; dREN = 1'b1; daddr = 32'h80; dstore = 32'hDEAD_BEEF;
    @(negedge CLK);
    @(negedge CLK);
    check_eq("t3_ramWEN", ramWEN, 32'h1);
    check_eq("t3_ramREN", ramREN, 32'h0);
    check_eq("t3_ramstore", ramstore, 32'hDEAD_BEEF);
    wait_done("t3", OWN_D, 20, c);
    step();
    dWEN = 1'b0; dREN = 1'b0;
    @(negedge CLK);
    check_eq("t3_dwait_one_cycle", dwait, 32'h1);
    step();
    dREN = 1'b1;
    wait_done("t3_rd", OWN_D, 20, c);
    check_eq("t3_readback", dload, 32'hDEAD_BEEF);
    go_idle(2);

    // 4: three ERROR cycles then ACCESS
    cfg_lat = 0; cfg_err = 3;
    dREN = 1'b1; daddr = 32'h100;
    wait_done("t4", OWN_D, 20, c);
    check_eq("t4_latency", c, 32'd4);
    step();
    cfg_err = 0;
    go_idle(2);

    // 5: async reset in the middle of a data transfer
    cfg_lat = 3;
    dREN = 1'b1; daddr = 32'h140;
    @(posedge CLK);
    @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    check_eq("t5_ramREN", ramREN, 32'h0);
    check_eq("t5_ramaddr", ramaddr, 32'h0);
    check_eq("t5_dwait", dwait, 32'h1);
    step();
    RST = 1'b0;
    @(negedge CLK);
    check_eq("t5_still_idle", ramREN, 32'h0);
    @(negedge CLK);
    check_eq("t5_regrant", ramREN, 32'h1);
    check_eq("t5_regrant_addr", ramaddr, 32'h140);
    wait_done("t5", OWN_D, 20, c);
    go_idle(2);

    // 6: data and fetch both held high; guard builds force every 5th grant to fetch
    cfg_lat = 0;
    base = obs_grants.size();
    dREN = 1'b1; daddr = 32'h200; iREN = 1'b1; iaddr = 32'h300;
    for (int k = 0; k < 30; k++) step();
    go_idle(2);
    for (int k = 0; k < 10; k++)
      check_eq($sformatf("t6_grant%0d", k), grant_at(base + k),
               (GUARD && (k == 4 || k == 9)) ? OWN_F : OWN_D);

    // Randomized requesters
    for (int n = 0; n < 800; n++) begin
      @(negedge CLK);
      i_fin = !iwait;
      d_fin = !dwait;
      step();
      cfg_lat = int'($urandom_range(0, 3));
      cfg_err = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0;
      if (iREN) begin
        if (i_fin) begin
          iREN = 1'($urandom_range(0, 1));
          iaddr = rand_addr();
        end else if ($urandom_range(0, 19) == 0) begin
          iREN = 1'b0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        iREN = 1'b1;
        iaddr = rand_addr();
      end
      if ((dREN | dWEN) && !d_fin) begin
        if ($urandom_range(0, 19) == 0) begin
          dREN = 1'b0; dWEN = 1'b0;
        end
      end else if ($urandom_range(0, 1) == 0) begin
        kind = int'($urandom_range(0, 3));
        dREN = (kind != 1);
        dWEN = (kind == 1) || (kind == 2);
        daddr = rand_addr();
        dstore = $urandom;
      end else begin
        dREN = 1'b0; dWEN = 1'b0;
      end
    end
    go_idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
